// File: rtl/seq_mul.sv
// Iterative radix-2 shift-add multiplier, full 2*DATA_WIDTH product with independent operand signedness.
// Latency: DATA_WIDTH cycles from the start edge to o_ready; one op per DATA_WIDTH+1 cycles back-to-back.
// Backpressure: none; i_start restarts any operation in flight, i_flush aborts it and returns to idle.
module seq_mul #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_multiplicand,
   input  logic [DATA_WIDTH-1:0] i_multiplier,
   input  logic                  i_a_signed,
   input  logic                  i_b_signed,
   input  logic                  i_start,
   input  logic                  i_flush,
   output logic [DATA_WIDTH-1:0] o_product_lo,
   output logic [DATA_WIDTH-1:0] o_product_hi,
   output logic                  o_ready
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   localparam logic [W-1:0]   ZERO_W   = '0;
   localparam logic [2*W-1:0] ZERO_2W  = '0;
   localparam logic [CW-1:0]  LAST_CNT = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

   // Architectural state
   logic            r_ready;
   logic [CW-1:0]   r_count;
   logic [W-1:0]    r_mcand;
   logic [2*W:0]    r_acc;
   logic            r_neg;

   // Next-state values
   logic            w_ready_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic [W-1:0]    w_mcand_nxt;
   logic [2*W:0]    w_acc_nxt;
   logic            w_neg_nxt;

   // Operand conditioning on the start edge: signs and unsigned magnitudes.
   // The magnitude of the most negative value is representable unsigned in W bits,
   // so no guard bit is needed on either operand.
   logic            w_sign_a;
   logic            w_sign_b;
   logic [W-1:0]    w_mag_a;
   logic [W-1:0]    w_mag_b;

   // One shift-add step; the upper half is W+1 bits so the add carry is kept
   // until the shift moves it into the product.
   logic [W:0]      w_addend;
   logic [W:0]      w_hi_sum;
   logic [2*W:0]    w_acc_step;

   // Signed result reconstruction from the magnitude product.
   logic [2*W-1:0]  w_mag_prod;
   logic [2*W-1:0]  w_product;

   // Derive operand signs and magnitudes from the raw inputs
   always_comb begin
      w_sign_a = i_a_signed & i_multiplicand[W-1];
      w_sign_b = i_b_signed & i_multiplier[W-1];
      w_mag_a  = w_sign_a ? (ZERO_W - i_multiplicand) : i_multiplicand;
      w_mag_b  = w_sign_b ? (ZERO_W - i_multiplier)   : i_multiplier;
   end

   // Conditional add of the multiplicand into the upper half, then a logical right shift
   always_comb begin
      w_addend   = r_acc[0] ? {1'b0, r_mcand} : {1'b0, ZERO_W};
      w_hi_sum   = r_acc[2*W:W] + w_addend;
      w_acc_step = {w_hi_sum, r_acc[W-1:0]} >> 1;
   end

   // Next-state selection: flush beats start, start beats an iteration step
   always_comb begin
      w_ready_nxt = r_ready;
      w_count_nxt = r_count;
      w_mcand_nxt = r_mcand;
      w_acc_nxt   = r_acc;
      w_neg_nxt   = r_neg;

      if (i_flush) begin
         // Abort: only the handshake state is cleared, datapath is left alone.
         w_ready_nxt = 1'b1;
         w_count_nxt = '0;
      end else if (i_start) begin
         w_ready_nxt = 1'b0;
         w_count_nxt = '0;
         w_mcand_nxt = w_mag_a;
         w_acc_nxt   = {{(W + 1){1'b0}}, w_mag_b};
         w_neg_nxt   = w_sign_a ^ w_sign_b;
      end else if (!r_ready) begin
         w_acc_nxt   = w_acc_step;
         w_count_nxt = r_count + ONE_CNT;
         if (r_count == LAST_CNT) begin
            w_ready_nxt = 1'b1;
         end
      end
   end

   // State register with synchronous active-high reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ready <= 1'b1;
         r_count <= '0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_neg   <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
         r_count <= w_count_nxt;
         r_mcand <= w_mcand_nxt;
         r_acc   <= w_acc_nxt;
         r_neg   <= w_neg_nxt;
      end
   end

   // Apply the result sign to the magnitude product and split into halves
   always_comb begin
      w_mag_prod   = r_acc[2*W-1:0];
      w_product    = r_neg ? (ZERO_2W - w_mag_prod) : w_mag_prod;
      o_product_hi = w_product[2*W-1:W];
      o_product_lo = w_product[W-1:0];
      o_ready      = r_ready;
   end

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: directed vector table, control sequences, random ops vs. arithmetic model.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
// All waits are fixed cycle counts, so the run always terminates.
module tb_seq_mul;

   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          a_s;
   logic          b_s;
   logic          start;
   logic          flush;
   logic [W-1:0]  p_lo;
   logic [W-1:0]  p_hi;
   logic          ready;

   int n_assert;
   int n_fail;

   seq_mul #(.DATA_WIDTH(W)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_multiplicand (a),
      .i_multiplier   (b),
      .i_a_signed     (a_s),
      .i_b_signed     (b_s),
      .i_start        (start),
      .i_flush        (flush),
      .o_product_lo   (p_lo),
      .o_product_hi   (p_hi),
      .o_ready        (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         as;
      logic         bs;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   // Reference: exact product of the two operands interpreted per their signedness.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic xs, input logic ys);
      logic signed [2*W+1:0] ex;
      logic signed [2*W+1:0] ey;
      logic signed [2*W+1:0] p;
      ex = {{(W + 2){xs & x[W-1]}}, x};
      ey = {{(W + 2){ys & y[W-1]}}, y};
      p  = ex * ey;
      return p[2*W-1:0];
   endfunction

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue start on the next edge (E0); returns 1 time unit after E0 with start low.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic xs, input logic ys);
      a = x; b = y; a_s = xs; b_s = ys; start = 1'b1;
      tick();
      start = 1'b0;
      a = $urandom; b = $urandom; a_s = 1'($urandom); b_s = 1'($urandom);
   endtask

   // Full op: busy through E0+31, ready with product at E0+32.
   task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic xs, input logic ys, input logic [2*W-1:0] exp);
      issue(x, y, xs, ys);
      repeat (W - 1) tick();
      chk({name, ".busy"}, {63'd0, ready}, 64'd0);
      tick();
      chk({name, ".ready"}, {63'd0, ready}, 64'd1);
      chk({name, ".prod"}, {p_hi, p_lo}, exp);
   endtask

   vec_t vecs[5];

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      a = '0; b = '0; a_s = 1'b0; b_s = 1'b0;

      vecs[0] = '{32'd7,        32'd6,        1'b0, 1'b0, 32'h00000000, 32'h0000002A};
      vecs[1] = '{32'hFFFFFFFD, 32'd5,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001};
      vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h00000000};
      vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001};

      tick(); tick();
      rst = 1'b0;
      chk("reset.ready", {63'd0, ready}, 64'd1);
      chk("reset.prod", {p_hi, p_lo}, 64'd0);

      // Directed table; each op starts the cycle after the previous one becomes ready.
      for (int i = 0; i < 5; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs,
                {vecs[i].hi, vecs[i].lo});
      end

      // Product holds while idle.
      repeat (4) tick();
      chk("hold.prod", {p_hi, p_lo}, 64'hFFFFFFFF_00000001);
      chk("hold.ready", {63'd0, ready}, 64'd1);

      // Flush 10 cycles after start.
      issue(32'd7, 32'd6, 1'b0, 1'b0);
      repeat (9) tick();
      chk("flush.busy", {63'd0, ready}, 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush.ready", {63'd0, ready}, 64'd1);
      tick();
      chk("flush.stays", {63'd0, ready}, 64'd1);

      // Restart 5 cycles into an operation; ready counts from the second start.
      issue(32'd7, 32'd6, 1'b0, 1'b0);
      repeat (4) tick();
      run_op("restart", 32'd3, 32'd4, 1'b0, 1'b0, 64'h0C);

      // Start and flush on the same edge: flush wins, nothing starts.
      a = 32'd9; b = 32'd9; a_s = 1'b0; b_s = 1'b0;
      start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      chk("sf.ready", {63'd0, ready}, 64'd1);
      tick();
      chk("sf.ready2", {63'd0, ready}, 64'd1);

      // Reset mid-operation at cycle 15.
      issue(32'd7, 32'd6, 1'b0, 1'b0);
      repeat (14) tick();
      chk("rst.busy", {63'd0, ready}, 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst.ready", {63'd0, ready}, 64'd1);
      chk("rst.prod", {p_hi, p_lo}, 64'd0);

      // Randomized operands and signedness against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] x;
         logic [W-1:0] y;
         logic xs;
         logic ys;
         x = $urandom; y = $urandom;
         xs = 1'($urandom); ys = 1'($urandom);
         if (i % 8 == 0) x = 32'h80000000;
         if (i % 8 == 1) y = 32'h00000000;
         if (i % 8 == 2) y = 32'h80000000;
         run_op($sformatf("rnd%0d", i), x, y, xs, ys, ref_mul(x, y, xs, ys));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_mul.md
# seq_mul

Iterative radix-2 shift-add multiplier, companion to the sequential divider in the integer execution unit. Accepts two DATA_WIDTH operands with independent signedness, produces the full 2*DATA_WIDTH product over DATA_WIDTH cycles, and uses the same start/flush/ready handshake as the divider so the issue logic drives both identically. Covers RISC-V MUL/MULH/MULHSU/MULHU: the consumer selects product_lo or product_hi.

## Interface

- DATA_WIDTH, 32, operand width; product is 2*DATA_WIDTH.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- multiplicand  in  DATA_WIDTH  operand A, sampled on the start edge.
- multiplier  in  DATA_WIDTH  operand B, sampled on the start edge.
- a_signed  in  1  A is two's complement when 1, unsigned when 0.
- b_signed  in  1  B is two's complement when 1, unsigned when 0.
- start  in  1  begin a new operation; one-cycle pulse.
- flush  in  1  abort the current operation.
- product_lo  out  DATA_WIDTH  low half of the product.
- product_hi  out  DATA_WIDTH  high half of the product.
- ready  out  1  idle; the product is valid.

## Operation

- Registered state: r_ready, r_count (clog2(DATA_WIDTH+1) bits), r_mcand (DATA_WIDTH, magnitude of A), r_acc (2*DATA_WIDTH+1 bits), r_neg.
- Start edge:
  - sA = a_signed & A[MSB], sB = b_signed & B[MSB].
  - r_mcand = sA ? -A : A; r_acc = {(DATA_WIDTH+1)'0, sB ? -B : B}.
  - r_neg = sA ^ sB; r_count = 0; r_ready = 0.
  - Magnitudes are unsigned DATA_WIDTH; the most negative value (0x80000000) has magnitude 0x80000000 and needs no extra bit.
- Iteration edge (r_ready = 0, no start, no flush):
  - hi = r_acc[2W:W] (W+1 bits). If r_acc[0], hi = hi + {0, r_mcand}.
  - r_acc = {hi, r_acc[W-1:0]} >> 1, logical.
  - r_count++. When r_count == DATA_WIDTH-1, r_ready = 1.
- After DATA_WIDTH iterations, r_acc[2W-1:0] = |A|*|B|.
- Output, combinational: P = r_neg ? -r_acc[2W-1:0] : r_acc[2W-1:0]; product_hi = P[2W-1:W]; product_lo = P[W-1:0].
- Edge priority: rst > flush > start > iteration.
  - flush: r_ready = 1 and r_count = 0. Other registers are left as-is; outputs after a flush are don't-care.
  - start while busy: restarts with the new operands. The old operation is discarded.
  - start and flush on the same edge: flush wins and start is ignored.
- Zero operands follow the normal path; there is no early termination, so latency is fixed.

## Timing

- Reset values:
  - ready = 1, product_lo = 0, product_hi = 0.
  - All internal registers 0, including r_neg = 0.
- start sampled on edge E0: ready = 0 from E0 until edge E0+DATA_WIDTH, then ready = 1 with the valid product.
- Latency is DATA_WIDTH cycles from the start edge to ready; throughput is one op per DATA_WIDTH+1 cycles when start is issued the cycle ready rises.
- start may be asserted in the same cycle ready is observed high. The product stays stable until the next start edge.
- Operand and signedness inputs are don't-care except on the start edge.
- rst asserted mid-operation: the next edge returns all state to reset values; ready = 1, product = 0.
- flush asserted on edge Ek: ready = 1 after Ek.

## Test plan

- Unsigned: A=7, B=6, a_signed=b_signed=0 -> after 32 cycles ready=1, hi=0x00000000, lo=0x0000002A.
- Signed: A=0xFFFFFFFD (-3), B=5, both signed -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned max: A=B=0xFFFFFFFF, both unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed min squared: A=B=0x80000000, both signed -> hi=0x40000000, lo=0x00000000.
- MULHSU: A=0xFFFFFFFF signed, B=0xFFFFFFFF unsigned -> hi=0xFFFFFFFF, lo=0x00000001.
- Control, all with A=7, B=6 unsigned:
  - flush 10 cycles after start -> ready=1 next cycle.
  - start again after 5 cycles with A=3, B=4 -> ready at start+32, lo=0x0C.
  - rst at cycle 15 -> ready=1, hi=lo=0 next cycle.
